// File: rtl/fifo_flex_pkg.sv
// rtl/fifo_flex_pkg.sv - shared constants for the fifo_flex slice
package fifo_flex_pkg;
`include "fifo_defs.vh"
   localparam int DEF_WORD_SIZE = `FIFO_DEF_WORD_SIZE;
   localparam int DEF_MEM_SIZE  = `FIFO_DEF_MEM_SIZE;
   localparam int DEF_PTR       = `FIFO_DEF_PTR;
   localparam int FWFT_OFF      = `FIFO_FWFT_OFF;
   localparam int FWFT_ON       = `FIFO_FWFT_ON;
endpackage

// File: rtl/fifo_defs.vh
// rtl/fifo_defs.vh - default geometry and read-mode constants for fifo_flex
`ifndef FIFO_DEFS_VH
`define FIFO_DEFS_VH
`define FIFO_DEF_WORD_SIZE 10
`define FIFO_DEF_MEM_SIZE  8
`define FIFO_DEF_PTR       3
`define FIFO_FWFT_OFF      0
`define FIFO_FWFT_ON       1
`endif

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - register-array storage, synchronous write, asynchronous read
module fifo_mem
   import fifo_flex_pkg::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int MEM_SIZE  = DEF_MEM_SIZE,
   parameter int PTR       = DEF_PTR
) (
   input  logic                 clk,
   input  logic                 push,
   input  logic [PTR-1:0]       wr_ptr,
   input  logic [WORD_SIZE-1:0] wr_data,
   input  logic [PTR-1:0]       rd_ptr,
   output logic [WORD_SIZE-1:0] rd_data
);

   // Contents are deliberately not reset; stale words are unreachable once pointers clear.
   logic [WORD_SIZE-1:0] mem [MEM_SIZE];

   // Store the incoming word at the write pointer on every accepted push.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_flex.sv
// rtl/fifo_flex.sv - parameterised FIFO with registered or fall-through read, thresholds and sticky errors
module fifo_flex
   import fifo_flex_pkg::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int MEM_SIZE  = DEF_MEM_SIZE,
   parameter int PTR       = DEF_PTR,
   parameter int FWFT      = FWFT_OFF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 fifo_wr,
   input  logic                 fifo_rd,
   input  logic [WORD_SIZE-1:0] fifo_data_in,
   input  logic [PTR:0]         full_threshold,
   input  logic [PTR:0]         empty_threshold,
   input  logic                 error_clr,
   output logic [WORD_SIZE-1:0] fifo_data_out,
   output logic                 fifo_valid,
   output logic [PTR:0]         fifo_count,
   output logic                 fifo_full,
   output logic                 fifo_empty,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic                 overflow,
   output logic                 underflow,
   output logic                 error
);

   logic [PTR-1:0]       wr_ptr, rd_ptr;
   logic [WORD_SIZE-1:0] rd_data;
   logic                 push, pop;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside a read.
   assign pop  = fifo_rd & ~fifo_empty;
   assign push = fifo_wr & (~fifo_full | pop);

   fifo_mem #(
      .WORD_SIZE(WORD_SIZE),
      .MEM_SIZE (MEM_SIZE),
      .PTR      (PTR)
   ) u_mem (
      .clk    (clk),
      .push   (push),
      .wr_ptr (wr_ptr),
      .wr_data(fifo_data_in),
      .rd_ptr (rd_ptr),
      .rd_data(rd_data)
   );

   // Pointers wrap naturally; occupancy tracks the net effect of push and pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   assign fifo_full    = (fifo_count == (PTR+1)'(MEM_SIZE));
   assign fifo_empty   = (fifo_count == '0);
   assign almost_full  = (fifo_count >= full_threshold);
   assign almost_empty = (fifo_count <= empty_threshold);

   // Error flags stay set until cleared; a fresh error in the clearing cycle wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (fifo_wr & ~push) overflow <= 1'b1;
         else if (error_clr)  overflow <= 1'b0;
         if (fifo_rd & fifo_empty) underflow <= 1'b1;
         else if (error_clr)       underflow <= 1'b0;
      end
   end

   assign error = overflow | underflow;

   if (FWFT == FWFT_ON) begin : g_fwft
      assign fifo_data_out = rd_data;
      assign fifo_valid    = ~fifo_empty;
   end else begin : g_reg
      logic [WORD_SIZE-1:0] data_q;
      logic                 valid_q;
      // Capture the head word on each pop; valid marks the single cycle that follows.
      always_ff @(posedge clk) begin
         if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            valid_q <= pop;
            if (pop) data_q <= rd_data;
         end
      end
      assign fifo_data_out = data_q;
      assign fifo_valid    = valid_q;
   end

endmodule

// File: tb/tb_fifo_flex.sv
// tb/tb_fifo_flex.sv - directed self-checking bench for fifo_flex in both read modes
module tb_fifo_flex;

   logic       clk = 1'b0;
   int         checks = 0;
   int         failures = 0;

   logic       reset, wr, rd, eclr;
   logic [9:0] din;
   logic [3:0] fth, eth;
   logic [9:0] dout;
   logic [3:0] count;
   logic       valid, full, empty, af, ae, ovf, unf, err;

   logic       b_reset, b_wr, b_rd, b_eclr;
   logic [9:0] b_din;
   logic [9:0] b_dout;
   logic [3:0] b_count;
   logic       b_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf, b_err;

   logic [9:0] sb [$];

   always #5 clk = ~clk;

   fifo_flex #(.WORD_SIZE(10), .MEM_SIZE(8), .PTR(3), .FWFT(0)) dut_reg (
      .clk(clk), .reset(reset), .fifo_wr(wr), .fifo_rd(rd), .fifo_data_in(din),
      .full_threshold(fth), .empty_threshold(eth), .error_clr(eclr),
      .fifo_data_out(dout), .fifo_valid(valid), .fifo_count(count),
      .fifo_full(full), .fifo_empty(empty), .almost_full(af), .almost_empty(ae),
      .overflow(ovf), .underflow(unf), .error(err)
   );

   fifo_flex #(.WORD_SIZE(10), .MEM_SIZE(8), .PTR(3), .FWFT(1)) dut_fwft (
      .clk(clk), .reset(b_reset), .fifo_wr(b_wr), .fifo_rd(b_rd), .fifo_data_in(b_din),
      .full_threshold(4'd6), .empty_threshold(4'd2), .error_clr(b_eclr),
      .fifo_data_out(b_dout), .fifo_valid(b_valid), .fifo_count(b_count),
      .fifo_full(b_full), .fifo_empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
      .overflow(b_ovf), .underflow(b_unf), .error(b_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; wr = 1'b0; rd = 1'b0; eclr = 1'b0; din = '0;
      tick();
      reset = 1'b0;
   endtask

   task automatic fill8(input int base);
      for (int i = 0; i < 8; i++) begin
         wr = 1'b1; din = 10'(base + i);
         tick();
      end
      wr = 1'b0;
   endtask

   task automatic test_reset();
      fth = 4'd6; eth = 4'd2;
      do_reset();
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_empty_full got=%b%b exp=10", empty, full); end
      checks++; if (ae !== 1'b1 || af !== 1'b0) begin failures++; $display("FAIL reset_almost got ae=%b af=%b exp ae=1 af=0", ae, af); end
      checks++; if (valid !== 1'b0 || dout !== 10'h000) begin failures++; $display("FAIL reset_out got valid=%b dout=%h exp 0 000", valid, dout); end
      checks++; if (ovf !== 1'b0 || unf !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_err got %b%b%b exp 000", ovf, unf, err); end
      fth = 4'd0; #1;
      checks++; if (af !== 1'b1) begin failures++; $display("FAIL reset_af_thr0 got=%b exp=1", af); end
      fth = 4'd6;
   endtask

   task automatic test_fill_drain();
      do_reset();
      fill8(1);
      checks++; if (full !== 1'b1 || count !== 4'd8) begin failures++; $display("FAIL fill_full got full=%b count=%0d exp 1 8", full, count); end
      for (int i = 1; i <= 8; i++) begin
         rd = 1'b1;
         tick();
         checks++; if (dout !== 10'(i) || valid !== 1'b1) begin failures++; $display("FAIL drain_data%0d got=%h v=%b exp=%h v=1", i, dout, valid, 10'(i)); end
      end
      rd = 1'b0;
      tick();
      checks++; if (empty !== 1'b1 || valid !== 1'b0) begin failures++; $display("FAIL drain_empty got empty=%b valid=%b exp 1 0", empty, valid); end
      checks++; if (dout !== 10'h008) begin failures++; $display("FAIL drain_hold got=%h exp=008", dout); end
   endtask

   task automatic test_overflow();
      do_reset();
      fill8(1);
      wr = 1'b1; din = 10'h3FF;
      tick();
      wr = 1'b0;
      checks++; if (ovf !== 1'b1 || err !== 1'b1 || count !== 4'd8) begin failures++; $display("FAIL ovf_set got ovf=%b err=%b count=%0d exp 1 1 8", ovf, err, count); end
      eclr = 1'b1;
      tick();
      eclr = 1'b0;
      checks++; if (ovf !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL ovf_clr got ovf=%b err=%b exp 0 0", ovf, err); end
      wr = 1'b1; din = 10'h3FF; eclr = 1'b1;
      tick();
      wr = 1'b0; eclr = 1'b0;
      checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", ovf); end
      for (int i = 1; i <= 8; i++) begin
         rd = 1'b1;
         tick();
         checks++; if (dout !== 10'(i)) begin failures++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, dout, 10'(i)); end
      end
      rd = 1'b0;
      tick();
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ovf_empty got=%b exp=1", empty); end
   endtask

   task automatic test_simultaneous();
      logic [9:0] exp_seq [8];
      exp_seq = '{10'h002, 10'h003, 10'h004, 10'h005, 10'h006, 10'h007, 10'h008, 10'h055};
      do_reset();
      fill8(1);
      wr = 1'b1; rd = 1'b1; din = 10'h055;
      tick();
      wr = 1'b0;
      checks++; if (count !== 4'd8 || dout !== 10'h001) begin failures++; $display("FAIL simul_full got count=%0d dout=%h exp 8 001", count, dout); end
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++; if (dout !== exp_seq[i]) begin failures++; $display("FAIL simul_drain%0d got=%h exp=%h", i, dout, exp_seq[i]); end
      end
      rd = 1'b0;
      tick();
      wr = 1'b1; rd = 1'b1; din = 10'h0AA;
      tick();
      wr = 1'b0; rd = 1'b0;
      checks++; if (count !== 4'd1 || unf !== 1'b1) begin failures++; $display("FAIL simul_empty got count=%0d unf=%b exp 1 1", count, unf); end
      checks++; if (valid !== 1'b0 || dout !== 10'h055) begin failures++; $display("FAIL simul_empty_out got v=%b dout=%h exp 0 055", valid, dout); end
   endtask

   task automatic test_thresholds();
      logic [8:0] ae_tab;
      logic [8:0] af_tab;
      ae_tab = 9'b000000111;
      af_tab = 9'b111000000;
      do_reset();
      fth = 4'd6; eth = 4'd2;
      for (int c = 0; c <= 8; c++) begin
         checks++; if (ae !== ae_tab[c] || af !== af_tab[c] || count !== 4'(c)) begin
            failures++; $display("FAIL thresh_c%0d got ae=%b af=%b count=%0d exp ae=%b af=%b", c, ae, af, count, ae_tab[c], af_tab[c]);
         end
         wr = (c < 8); din = 10'(c);
         tick();
      end
      wr = 1'b0;
   endtask

   task automatic test_mid_reset();
      do_reset();
      rd = 1'b1;
      tick();
      rd = 1'b0;
      checks++; if (unf !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL empty_rd_unf got unf=%b err=%b exp 1 1", unf, err); end
      for (int i = 0; i < 5; i++) begin
         wr = 1'b1; din = 10'(16 + i);
         tick();
      end
      checks++; if (count !== 4'd5) begin failures++; $display("FAIL mid_pre_count got=%0d exp=5", count); end
      reset = 1'b1; wr = 1'b1; rd = 1'b1;
      tick();
      reset = 1'b0; wr = 1'b0; rd = 1'b0;
      checks++; if (count !== 4'd0 || empty !== 1'b1 || valid !== 1'b0 || err !== 1'b0) begin
         failures++; $display("FAIL mid_reset got count=%0d empty=%b valid=%b err=%b exp 0 1 0 0", count, empty, valid, err);
      end
   endtask

   task automatic test_fwft_wrap();
      logic [9:0] w;
      int         op;
      b_reset = 1'b1; b_wr = 1'b0; b_rd = 1'b0; b_eclr = 1'b0; b_din = '0;
      tick();
      b_reset = 1'b0;
      checks++; if (b_valid !== 1'b0 || b_empty !== 1'b1) begin failures++; $display("FAIL fwft_reset got valid=%b empty=%b exp 0 1", b_valid, b_empty); end
      sb.delete();
      for (int i = 0; i < 4; i++) begin
         w = 10'(32'h100 + i * 7);
         b_wr = 1'b1; b_din = w; sb.push_back(w);
         tick();
      end
      b_wr = 1'b0;
      for (int i = 0; i < 20; i++) begin
         checks++; if (b_valid !== ~b_empty) begin failures++; $display("FAIL fwft_valid%0d got valid=%b empty=%b", i, b_valid, b_empty); end
         if (sb.size() <= 3) op = 0;
         else if (sb.size() >= 5) op = 1;
         else op = int'($urandom_range(0, 1));
         if (op == 1) begin
            checks++; if (b_dout !== sb[0]) begin failures++; $display("FAIL fwft_data%0d got=%h exp=%h", i, b_dout, sb[0]); end
            void'(sb.pop_front());
            b_rd = 1'b1;
         end else begin
            w = 10'($urandom_range(0, 1023));
            b_din = w; b_wr = 1'b1; sb.push_back(w);
         end
         tick();
         b_wr = 1'b0; b_rd = 1'b0;
      end
      checks++; if (b_count !== 4'(sb.size())) begin failures++; $display("FAIL fwft_count got=%0d exp=%0d", b_count, sb.size()); end
      checks++; if (b_err !== 1'b0) begin failures++; $display("FAIL fwft_err got=%b exp=0", b_err); end
   endtask

   initial begin
      reset = 1'b1; wr = 1'b0; rd = 1'b0; eclr = 1'b0; din = '0; fth = 4'd6; eth = 4'd2;
      b_reset = 1'b1; b_wr = 1'b0; b_rd = 1'b0; b_eclr = 1'b0; b_din = '0;
      test_reset();
      test_fill_drain();
      test_overflow();
      test_simultaneous();
      test_thresholds();
      test_mid_reset();
      test_fwft_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_flex.md
FIFO_FLEX -- requirements
Module: fifo_flex

Interface
REQ-001 SHALL provide parameter WORD_SIZE, default 10, data word width in bits ([WORD_SIZE-1:WORD_SIZE-2] destination, remainder payload).
REQ-002 SHALL provide parameter MEM_SIZE, default 8, FIFO depth in words; MEM_SIZE SHALL equal 2**PTR.
REQ-003 SHALL provide parameter PTR, default 3, pointer width in bits.
REQ-004 SHALL provide parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-005 SHALL have one clock and a synchronous, active-high reset, with ports ordered as follows:
- clk  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high reset
- fifo_wr  input  1  write request
- fifo_rd  input  1  read request
- fifo_data_in  input  WORD_SIZE  write data
- full_threshold  input  PTR+1  almost_full level
- empty_threshold  input  PTR+1  almost_empty level
- error_clr  input  1  clears sticky error flags
- fifo_data_out  output  WORD_SIZE  read data
- fifo_valid  output  1  fifo_data_out holds valid data
- fifo_count  output  PTR+1  current occupancy, 0..MEM_SIZE
- fifo_full, fifo_empty, almost_full, almost_empty  output  1 each  status flags
- overflow, underflow  output  1 each  sticky error flags
- error  output  1  overflow | underflow

Function
REQ-006 push SHALL equal fifo_wr & (!fifo_full | pop); on push, mem[wr_ptr] <= fifo_data_in and wr_ptr increments.
REQ-007 pop SHALL equal fifo_rd & !fifo_empty; on pop, rd_ptr increments.
REQ-008 wr_ptr and rd_ptr SHALL be PTR bits wide and SHALL wrap from MEM_SIZE-1 to 0 by natural overflow.
REQ-009 fifo_count SHALL update as follows: +1 on push only, -1 on pop only, unchanged on push&pop or neither.
REQ-010 fifo_full SHALL equal (fifo_count==MEM_SIZE), and fifo_empty SHALL equal (fifo_count==0).
REQ-011 almost_full SHALL equal (fifo_count>=full_threshold), and almost_empty SHALL equal (fifo_count<=empty_threshold); thresholds SHALL be used unregistered.
REQ-012 All status flags SHALL be decoded from registered fifo_count and SHALL reflect a push/pop in the cycle after it.
REQ-013 When full, simultaneous fifo_wr&fifo_rd SHALL both succeed, with count remaining MEM_SIZE.
REQ-014 When empty, simultaneous fifo_wr&fifo_rd SHALL accept the write, SHALL reject the read, and SHALL set underflow.
REQ-015 With FWFT=0, fifo_data_out SHALL load mem[rd_ptr] on the clock edge of a pop, and fifo_valid SHALL be 1 for exactly the following cycle (read latency 1); fifo_data_out SHALL hold otherwise.
REQ-016 With FWFT=1, fifo_data_out SHALL equal mem[rd_ptr] combinationally and fifo_valid SHALL equal !fifo_empty; fifo_rd SHALL acknowledge the displayed word.
REQ-017 fifo_wr while full without pop SHALL discard data, leave all pointers and the count unchanged, and set overflow.
REQ-018 fifo_rd while empty SHALL leave the pointers and fifo_data_out unchanged and set underflow.
REQ-019 overflow and underflow SHALL be sticky until error_clr; if error_clr and a new error occur in the same cycle, set SHALL win.

Reset
REQ-020 On reset=1 at a clock edge, wr_ptr, rd_ptr and fifo_count SHALL go to 0 and fifo_data_out to 0.
REQ-021 On reset=1 at a clock edge, fifo_valid, overflow and underflow SHALL go to 0.
REQ-022 After reset, fifo_empty=1, fifo_full=0, almost_empty=1, and almost_full=(full_threshold==0).
REQ-023 Memory contents SHALL NOT be reset; reset mid-operation SHALL discard all stored words and take priority over push/pop in that cycle.

Structure
REQ-024 Shared include fifo_defs.vh SHALL hold default WORD_SIZE/MEM_SIZE/PTR and FWFT mode constants (FWFT_OFF=0, FWFT_ON=1).
REQ-025 Storage SHALL be a sub-module fifo_mem: a MEM_SIZE x WORD_SIZE register array with synchronous write port (push, wr_ptr, data) and asynchronous read port (rd_ptr).
REQ-026 Pointer, count, flag and error logic SHALL live in fifo_flex; no other sub-modules.

Verification
REQ-027 Fill/drain (FWFT=0): reset, write 0x001..0x008 over 8 cycles -> fifo_full=1, count=8; read 8 -> data 0x001..0x008 each 1 cycle after its rd, then fifo_empty=1.
REQ-028 Overflow: full FIFO, fifo_wr with 0x3FF, no rd -> overflow=1, error=1, count=8, 0x3FF never read; error_clr pulse -> overflow=0 next cycle.
REQ-029 Simultaneous ops: count=8, wr 0x055 + rd together -> count stays 8, 0x055 read last; count=0, wr+rd -> count=1, underflow=1.
REQ-030 Thresholds: full_threshold=6, empty_threshold=2 -> almost_empty=1 for counts 0..2, almost_full=1 for counts 6..8, both 0 at count 3..5.
REQ-031 Wrap and mode: FWFT=1, 20 interleaved random writes/reads at count 3..5 -> data order matches a scoreboard across pointer wrap, fifo_valid==!fifo_empty every cycle.
REQ-032 Reset mid-operation: count=5, assert reset together with wr+rd -> next cycle count=0, fifo_empty=1, fifo_valid=0, error=0.
